serial_adder: RTL and testbench

- Bit-serial adder that takes two WIDTH-bit operands and a carry-in through a valid/ready input handshake.
- Adds one bit per clock, LSB first, through a single instantiated full_adder cell (ports a, b, cin, sum, carry) and a registered carry.
- Presents the WIDTH-bit sum and carry-out through a valid/ready output handshake.
- Sits as the sequencing stage around the full_adder cell: area-cheap alternative to a ripple-carry array for wide operands.

---
 rtl/serial_adder.sv | 110 +++++++++++
 tb/tb_serial_adder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder sequencing one full_adder cell, LSB first
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic [WIDTH-1:0] s_sh_d;
    logic [WIDTH-1:0] fa_msb;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_sum;
    logic             fa_carry;

    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    always_comb begin
        fa_msb            = '0;
        fa_msb[WIDTH-1]   = fa_sum;
        s_sh_d            = (s_sh_q >> 1) | fa_msb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        s_sh_q  <= '0;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    s_sh_q  <= s_sh_d;
                    carry_q <= fa_carry;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_q   <= s_sh_d;
                        cout_q  <= fa_carry;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH 8 and WIDTH 1
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1, cin8 = 1'b0, cout8, busy8;
    logic [7:0] a8 = '0, b8 = '0, sum8;

    logic       in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, cin1 = 1'b0, cout1, busy1;
    logic [0:0] a1 = '0, b1 = '0, sum1;

    int errors = 0;
    int checks = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];

    // {cout,sum} for WIDTH=1, indexed by {a,b,cin}
    logic [1:0] fa_table [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors pop the scoreboard whenever a result is handed off.
    always @(negedge clk) begin
        if (rst_n && out_valid8 && out_ready8) begin
            if (q8.size() == 0) chk("w8_unexpected_result", {cout8, sum8}, 9'h1ff);
            else chk("w8_result", {55'd0, cout8, sum8}, {55'd0, q8.pop_front()});
        end
        if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) chk("w1_unexpected_result", {cout1, sum1}, 2'd3);
            else chk("w1_result", {62'd0, cout1, sum1}, {62'd0, q1.pop_front()});
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [8:0] exp, input bit push);
        a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
        if (push) q8.push_back(exp);
        step();
        in_valid8 = 1'b0;
    endtask

    task automatic wait_done8(output int cycles, output int busy_cnt);
        cycles = 0;
        busy_cnt = 0;
        while (!out_valid8 && cycles < 200) begin
            if (busy8) busy_cnt++;
            step();
            cycles++;
        end
        if (!out_valid8) chk("w8_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int cyc, bcnt;

        repeat (3) step();
        #1;
        chk("rst_in_ready", in_ready8, 1);
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready8, 1);

        issue8(8'h5A, 8'h33, 1'b0, 9'h08D, 1);
        wait_done8(cyc, bcnt);
        chk("latency_5a_33", cyc, 8);
        chk("busy_cycles", bcnt, 8);
        chk("done_in_ready", in_ready8, 0);
        step();
        chk("back_to_idle", in_ready8, 1);

        issue8(8'hFF, 8'h01, 1'b0, 9'h100, 1);
        wait_done8(cyc, bcnt);
        step();
        issue8(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1);
        wait_done8(cyc, bcnt);
        step();

        out_ready8 = 1'b0;
        issue8(8'h10, 8'h20, 1'b0, 9'h030, 1);
        wait_done8(cyc, bcnt);
        a8 = 8'hAA; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid8, 1);
            chk("bp_sum_cout", {cout8, sum8}, 9'h030);
            chk("bp_in_ready", in_ready8, 0);
            step();
        end
        q8.push_back(9'h0AB);
        out_ready8 = 1'b1;
        step();
        chk("bp_release_idle", in_ready8, 1);
        step();
        in_valid8 = 1'b0;
        chk("bp_aa_accepted", busy8, 1);
        wait_done8(cyc, bcnt);
        step();

        issue8(8'hFF, 8'hFF, 1'b1, 9'h000, 0);
        repeat (3) step();
        chk("mid_run_busy", busy8, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready8, 1);
        chk("midrst_busy", busy8, 0);
        chk("midrst_out_valid", out_valid8, 0);
        chk("midrst_sum_cout", {cout8, sum8}, 9'h000);
        step();
        rst_n = 1'b1;
        step();
        issue8(8'h00, 8'h00, 1'b0, 9'h000, 1);
        wait_done8(cyc, bcnt);
        chk("post_rst_latency", cyc, 8);
        step();

        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            int c1;
            vv = 3'(v);
            a1 = vv[2]; b1 = vv[1]; cin1 = vv[0]; in_valid1 = 1'b1;
            q1.push_back(fa_table[v]);
            step();
            in_valid1 = 1'b0;
            c1 = 0;
            while (!out_valid1 && c1 < 20) begin
                step();
                c1++;
            end
            chk("w1_latency", c1, 1);
            step();
            chk("w1_idle", in_ready1, 1);
        end

        for (int i = 0; i < 20 && (q8.size() != 0 || q1.size() != 0); i++) step();
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
